// File: rtl/fifo_wr_arb.sv
// rtl/fifo_wr_arb.sv - round-robin packet arbiter feeding a single FIFO write port
// Optional: define FIFO_WR_ARB_TAG_EN to prefix wr_dat with the granted requester index.

module fifo_wr_arb #(
  parameter int NREQ   = 4,
  parameter int WIDTH  = 32,
  parameter int MAXLEN = 16,
  localparam int IDW   = $clog2(NREQ),
`ifdef FIFO_WR_ARB_TAG_EN
  localparam int OW    = WIDTH + IDW
`else
  localparam int OW    = WIDTH
`endif
) (
  input  logic                  clk,
  input  logic                  rst_b,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_dat,
  input  logic [NREQ-1:0]       req_last,
  output logic [NREQ-1:0]       req_ack,
  output logic [NREQ-1:0]       grant,
  input  logic                  full,
  output logic                  wr_en,
  output logic [OW-1:0]         wr_dat,
  output logic                  busy,
  output logic                  err_overlen
);

  localparam int CW = $clog2(MAXLEN);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [NREQ-1:0]  grant_q, grant_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             err_q, err_d;

  logic             win_found;
  logic [IDW-1:0]   win_idx;
  logic [IDW-1:0]   cand;
  logic [WIDTH-1:0] dat_arr [NREQ];
  logic [WIDTH-1:0] payload;
  logic             pkt_end;

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign dat_arr[i] = req_dat[i*WIDTH +: WIDTH];
  end

  // rr_ptr_q always holds the most recent winner, so it doubles as the granted index.
  assign busy        = (state_q == BUSY);
  assign wr_en       = busy & req_valid[rr_ptr_q] & ~full;
  assign req_ack     = grant_q & {NREQ{wr_en}};
  assign grant       = grant_q;
  assign err_overlen = err_q;
  assign payload     = dat_arr[rr_ptr_q];
  assign pkt_end     = req_last[rr_ptr_q] | (cnt_q == CW'(MAXLEN - 1));

`ifdef FIFO_WR_ARB_TAG_EN
  assign wr_dat = {rr_ptr_q, payload};
`else
  assign wr_dat = payload;
`endif

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IDW'((int'(rr_ptr_q) + k) % NREQ);
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        grant_d = '0;
        if (win_found) begin
          state_d  = BUSY;
          grant_d  = NREQ'(1) << win_idx;
          rr_ptr_d = win_idx;
          cnt_d    = '0;
        end
      end
      BUSY: begin
        if (wr_en) begin
          cnt_d = cnt_q + CW'(1);
          // A beat reaching MAXLEN without last ends the packet just like a last beat.
          if (pkt_end) begin
            state_d = IDLE;
            grant_d = '0;
            if (!req_last[rr_ptr_q]) begin
              err_d = 1'b1;
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= IDW'(NREQ - 1);
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// tb/tb_fifo_wr_arb.sv - directed bench for fifo_wr_arb with a packet-level reference model
// Honours FIFO_WR_ARB_TAG_EN for the wr_dat width and expected tag.

module tb_fifo_wr_arb;

  localparam int NREQ   = 4;
  localparam int WIDTH  = 32;
  localparam int MAXLEN = 16;
  localparam int IDW    = 2;
`ifdef FIFO_WR_ARB_TAG_EN
  localparam int OW     = WIDTH + IDW;
`else
  localparam int OW     = WIDTH;
`endif

  logic                  clk = 1'b0;
  logic                  rst_b = 1'b0;
  logic [NREQ-1:0]       req_valid = '0;
  logic [NREQ*WIDTH-1:0] req_dat = '0;
  logic [NREQ-1:0]       req_last = '0;
  logic [NREQ-1:0]       req_ack;
  logic [NREQ-1:0]       grant;
  logic                  full = 1'b0;
  logic                  wr_en;
  logic [OW-1:0]         wr_dat;
  logic                  busy;
  logic                  err_overlen;

  fifo_wr_arb #(.NREQ(NREQ), .WIDTH(WIDTH), .MAXLEN(MAXLEN)) dut (
    .clk(clk), .rst_b(rst_b), .req_valid(req_valid), .req_dat(req_dat),
    .req_last(req_last), .req_ack(req_ack), .grant(grant), .full(full),
    .wr_en(wr_en), .wr_dat(wr_dat), .busy(busy), .err_overlen(err_overlen)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int n_writes = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: owner index (-1 when nobody owns the port), last winner, beat count.
  int m_owner = -1;
  int m_rr    = NREQ - 1;
  int m_cnt   = 0;
  bit m_err   = 1'b0;
  int grant_log[$];

  task automatic model_step();
    int j;
    bit picked;
    if (!rst_b) begin
      m_owner = -1;
      m_rr    = NREQ - 1;
      m_cnt   = 0;
      m_err   = 1'b0;
    end else if (m_owner < 0) begin
      picked = 1'b0;
      for (int k = 1; k <= NREQ; k++) begin
        j = (m_rr + k) % NREQ;
        if (!picked && req_valid[j]) begin
          picked  = 1'b1;
          m_owner = j;
          m_rr    = j;
          m_cnt   = 0;
          grant_log.push_back(j);
        end
      end
    end else if (req_valid[m_owner] && !full) begin
      m_cnt++;
      if (req_last[m_owner]) begin
        m_owner = -1;
      end else if (m_cnt == MAXLEN) begin
        m_err   = 1'b1;
        m_owner = -1;
      end
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_b);
    model_step();
  end

  task automatic compare();
    logic [NREQ-1:0] eg;
    logic            ew;
    logic [63:0]     ed;
    eg = '0;
    ew = 1'b0;
    if (m_owner >= 0) begin
      eg = NREQ'(1) << m_owner;
      ew = req_valid[m_owner] && !full;
    end
    check("grant", 64'(grant), 64'(eg));
    check("wr_en", 64'(wr_en), 64'(ew));
    check("req_ack", 64'(req_ack), ew ? 64'(eg) : 64'(0));
    check("busy", 64'(busy), 64'(m_owner >= 0));
    check("err_overlen", 64'(err_overlen), 64'(m_err));
    if (ew) begin
      ed = 64'(WIDTH'(req_dat >> (m_owner * WIDTH)));
`ifdef FIFO_WR_ARB_TAG_EN
      ed = ed | (64'(m_owner) << WIDTH);
`endif
      check("wr_dat", 64'(wr_dat), ed);
      n_writes++;
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (rst_b === 1'b1) compare();
  end

  // Requester driver: each requester walks a queue of packet lengths, one beat per ack.
  int              q_len[NREQ][$];
  int              beat[NREQ];
  int              pkt[NREQ];
  bit              nolast = 1'b0;
  logic [NREQ-1:0] hold = '0;

  task automatic drive();
    logic [WIDTH-1:0] d [NREQ];
    for (int i = 0; i < NREQ; i++) begin
      if (q_len[i].size() > 0 && !hold[i]) begin
        req_valid[i] = 1'b1;
        req_last[i]  = !nolast && (beat[i] == q_len[i][0] - 1);
        d[i]         = {4'(i), 12'(pkt[i]), 16'(beat[i])};
      end else begin
        req_valid[i] = 1'b0;
        req_last[i]  = 1'b0;
        d[i]         = '0;
      end
    end
    req_dat = {d[3], d[2], d[1], d[0]};
  endtask

  task automatic cyc();
    logic [NREQ-1:0] a;
    drive();
    @(negedge clk);
    a = req_ack;
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (a[i] && q_len[i].size() > 0) begin
        beat[i]++;
        if (beat[i] == q_len[i][0]) begin
          void'(q_len[i].pop_front());
          beat[i] = 0;
          pkt[i]++;
        end
      end
    end
  endtask

  function automatic bit pending();
    for (int i = 0; i < NREQ; i++) if (q_len[i].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic run_all(input int budget, output int steps);
    steps = 0;
    while (pending() && steps < budget) begin
      cyc();
      steps++;
    end
    check("drain_in_budget", 64'(pending()), 64'(0));
  endtask

  task automatic do_reset();
    rst_b = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      q_len[i].delete();
      beat[i] = 0;
      pkt[i]  = 0;
    end
    nolast = 1'b0;
    hold   = '0;
    full   = 1'b0;
    drive();
    @(posedge clk);
    #1;
    check("rst_grant", 64'(grant), 64'(0));
    check("rst_wr_en", 64'(wr_en), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_err", 64'(err_overlen), 64'(0));
    @(posedge clk);
    #3;
    rst_b = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before the summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int steps;
    int w0;
    int exp_ord[5] = '{0, 1, 2, 3, 0};

    do_reset();
    repeat (3) cyc();
    check("idle_grant", 64'(grant), 64'(0));
    check("idle_busy", 64'(busy), 64'(0));

    // First arbitration after reset: 1 then 3.
    q_len[1].push_back(1);
    q_len[3].push_back(1);
    cyc();
    check("r032_grant1", 64'(grant), 64'(4'b0010));
    cyc();
    check("r032_bubble", 64'(grant), 64'(0));
    cyc();
    check("r032_grant3", 64'(grant), 64'(4'b1000));
    cyc();
    check("r032_done", 64'(grant), 64'(0));

    // Continuous 2-beat packets from all requesters.
    do_reset();
    grant_log.delete();
    w0 = n_writes;
    q_len[0].push_back(2);
    q_len[0].push_back(2);
    for (int i = 1; i < NREQ; i++) q_len[i].push_back(2);
    run_all(40, steps);
    check("r033_cycles", 64'(steps), 64'(15));
    check("r033_writes", 64'(n_writes - w0), 64'(10));
    check("r033_npkts", 64'(grant_log.size()), 64'(5));
    for (int k = 0; k < 5; k++) begin
      check("r033_order", 64'(k < grant_log.size() ? grant_log[k] : -1), 64'(exp_ord[k]));
    end

    // Back-pressure in the middle of requester 2's packet.
    do_reset();
    w0 = n_writes;
    q_len[2].push_back(3);
    cyc();
    check("r034_grant", 64'(grant), 64'(4'b0100));
    cyc();
    full = 1'b1;
    drive();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("r034_wr_en", 64'(wr_en), 64'(0));
      check("r034_ack", 64'(req_ack), 64'(0));
      check("r034_grant_held", 64'(grant), 64'(4'b0100));
      @(posedge clk);
      #1;
    end
    full = 1'b0;
    run_all(20, steps);
    check("r034_writes", 64'(n_writes - w0), 64'(3));

    // Owner's valid drops mid-packet while another requester waits.
    do_reset();
    q_len[0].push_back(3);
    q_len[1].push_back(1);
    cyc();
    check("r026_grant", 64'(grant), 64'(4'b0001));
    cyc();
    hold[0] = 1'b1;
    repeat (3) begin
      cyc();
      check("r026_grant_held", 64'(grant), 64'(4'b0001));
      check("r026_stalled", 64'(wr_en), 64'(0));
    end
    hold[0] = 1'b0;
    grant_log.delete();
    run_all(20, steps);
    check("r026_next", 64'(grant_log.size() > 0 ? grant_log[0] : -1), 64'(1));

    // Over-length packet: 20 beats offered with no last.
    do_reset();
    w0 = n_writes;
    nolast = 1'b1;
    q_len[0].push_back(20);
    cyc();
    check("r035_grant", 64'(grant), 64'(4'b0001));
    for (int k = 0; k < 40 && grant !== '0; k++) cyc();
    q_len[0].delete();
    beat[0] = 0;
    nolast = 1'b0;
    drive();
    check("r035_writes", 64'(n_writes - w0), 64'(16));
    check("r035_err", 64'(err_overlen), 64'(1));
    check("r035_released", 64'(grant), 64'(0));
    repeat (4) cyc();
    check("r035_err_sticky", 64'(err_overlen), 64'(1));
    check("r035_idle", 64'(busy), 64'(0));

    // Asynchronous reset while requester 1 is at beat 3.
    do_reset();
    q_len[1].push_back(6);
    for (int k = 0; k < 10 && beat[1] != 3; k++) cyc();
    drive();
    check("r036_pre_grant", 64'(grant), 64'(4'b0010));
    check("r036_pre_wr", 64'(wr_en), 64'(1));
    #1;
    rst_b = 1'b0;
    #1;
    check("r036_grant_drop", 64'(grant), 64'(0));
    check("r036_wr_drop", 64'(wr_en), 64'(0));
    check("r036_ack_drop", 64'(req_ack), 64'(0));
    do_reset();
    q_len[0].push_back(1);
    q_len[1].push_back(2);
    cyc();
    check("r036_next", 64'(grant), 64'(4'b0001));
    run_all(20, steps);

    // Payload (and optional tag) from requester 3.
    do_reset();
    req_valid = 4'b1000;
    req_last  = 4'b1000;
    req_dat   = {32'hDEADBEEF, 96'h0};
    @(posedge clk);
    #1;
    check("r037_grant", 64'(grant), 64'(4'b1000));
    check("r037_wr_en", 64'(wr_en), 64'(1));
`ifdef FIFO_WR_ARB_TAG_EN
    check("r037_wr_dat", 64'(wr_dat), 64'h3_DEAD_BEEF);
`else
    check("r037_wr_dat", 64'(wr_dat), 64'hDEAD_BEEF);
`endif
    @(posedge clk);
    #1;
    req_valid = '0;
    req_last  = '0;
    check("r037_done", 64'(grant), 64'(0));
    repeat (2) @(posedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
